// File: rtl/pid_output_pkg.sv
// Shared constants and FSM encodings for pid_output_router.
// The optional coalesce counter is enabled by PID_OUTPUT_ROUTER_STATS_EN.
package pid_output_pkg;

    localparam logic [1:0] SEL_FREQ  = 2'd0;
    localparam logic [1:0] SEL_PHASE = 2'd1;
    localparam logic [1:0] SEL_AMP   = 2'd2;

    localparam int FREQ0_ADDR_DEF  = 8;
    localparam int PHASE0_ADDR_DEF = 12;
    localparam int AMP0_ADDR_DEF   = 16;

    typedef enum logic {
        DAC_IDLE,
        DAC_SEND
    } dac_state_t;

    typedef enum logic {
        DDS_IDLE,
        DDS_BUSY
    } dds_state_t;

endpackage

// File: rtl/pid_output_router_if.sv
// DAC output stream of pid_output_router (valid/ready).
// master = router, slave = DAC sink.
interface pid_output_router_if #(
    parameter int W_DAC_CHAN = 3,
    parameter int W_DAC_DATA = 16
);
    logic                  dac_dv_out;
    logic                  dac_rdy_in;
    logic [W_DAC_CHAN-1:0] dac_chan_out;
    logic [W_DAC_DATA-1:0] dac_data_out;

    modport master (
        output dac_dv_out,
        output dac_chan_out,
        output dac_data_out,
        input  dac_rdy_in
    );

    modport slave (
        input  dac_dv_out,
        input  dac_chan_out,
        input  dac_data_out,
        output dac_rdy_in
    );
endinterface

// File: rtl/dds_update_sequencer.sv
// Latest-wins freq/phase/amp registers for one DDS and its
// IDLE/BUSY serial-update FSM (freq > phase > amp).
module dds_update_sequencer
    import pid_output_pkg::*;
#(
    parameter int W_FREQ  = 48,
    parameter int W_PHASE = 14,
    parameter int W_AMP   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [1:0]        wr_sel,
    input  logic [W_FREQ-1:0] wr_data,
    input  logic              done,
    output logic              dv,
    output logic [1:0]        sel,
    output logic [W_FREQ-1:0] data,
    output logic              coalesce
);

    logic [W_FREQ-1:0]  freq;
    logic [W_PHASE-1:0] phase;
    logic [W_AMP-1:0]   amp;
    logic [2:0]         pend;
    logic [2:0]         hit;
    logic [2:0]         clr;
    dds_state_t         state;

    always_comb begin
        hit = '0;
        if (wr) begin
            unique case (wr_sel)
                SEL_FREQ:  hit[0] = 1'b1;
                SEL_PHASE: hit[1] = 1'b1;
                SEL_AMP:   hit[2] = 1'b1;
                default:   hit = '0;
            endcase
        end
    end

    // lowest set bit is the highest-priority pending target
    assign clr = (state == DDS_IDLE) ? (pend & (~pend + 3'd1)) : '0;
    assign coalesce = |(hit & pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DDS_IDLE;
            dv    <= 1'b0;
            sel   <= '0;
            data  <= '0;
            pend  <= '0;
            freq  <= '0;
            phase <= '0;
            amp   <= '0;
        end else begin
            dv   <= 1'b0;
            pend <= (pend & ~clr) | hit;
            if (hit[0]) freq  <= wr_data;
            if (hit[1]) phase <= wr_data[W_PHASE-1:0];
            if (hit[2]) amp   <= wr_data[W_AMP-1:0];
            unique case (state)
                DDS_IDLE: begin
                    if (|pend) begin
                        dv    <= 1'b1;
                        state <= DDS_BUSY;
                        if (pend[0]) begin
                            sel  <= SEL_FREQ;
                            data <= freq;
                        end else if (pend[1]) begin
                            sel  <= SEL_PHASE;
                            data <= W_FREQ'(phase);
                        end else begin
                            sel  <= SEL_AMP;
                            data <= W_FREQ'(amp);
                        end
                    end
                end
                DDS_BUSY: begin
                    if (done) state <= DDS_IDLE;
                end
                default: state <= DDS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pid_output_router.sv
// Routes pipeline results to latest-wins DAC/DDS registers and drains them.
// Define PID_OUTPUT_ROUTER_STATS_EN to add coalesce_cnt_out.
module pid_output_router
    import pid_output_pkg::*;
#(
    parameter int N_DAC       = 8,
    parameter int N_DDS       = 4,
    parameter int W_CHAN      = 5,
    parameter int W_DIN       = 48,
    parameter int W_DAC_CHAN  = 3,
    parameter int W_DAC_DATA  = 16,
    parameter int W_FREQ      = 48,
    parameter int W_PHASE     = 14,
    parameter int W_AMP       = 10,
    parameter int FREQ0_ADDR  = FREQ0_ADDR_DEF,
    parameter int PHASE0_ADDR = PHASE0_ADDR_DEF,
    parameter int AMP0_ADDR   = AMP0_ADDR_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    dv_in,
    input  logic [W_CHAN-1:0]       chan_in,
    input  logic [W_DIN-1:0]        data_in,
    pid_output_router_if.master     dac,
    output logic [N_DDS-1:0]        dds_dv_out,
    output logic [2*N_DDS-1:0]      dds_sel_out,
    output logic [W_FREQ*N_DDS-1:0] dds_data_out,
    input  logic [N_DDS-1:0]        dds_done_in
`ifdef PID_OUTPUT_ROUTER_STATS_EN
    ,
    output logic [15:0]             coalesce_cnt_out
`endif
);

    logic              r_dv;
    logic [W_CHAN-1:0] r_chan;
    logic [W_DIN-1:0]  r_data;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_dv   <= 1'b0;
            r_chan <= '0;
            r_data <= '0;
        end else begin
            r_dv   <= dv_in;
            r_chan <= chan_in;
            r_data <= data_in;
        end
    end

    logic [W_DAC_DATA-1:0] dac_val [N_DAC];
    logic [N_DAC-1:0]      dac_pend;
    logic [N_DAC-1:0]      dac_hit;
    logic [N_DAC-1:0]      dac_clr;
    logic [W_DAC_CHAN-1:0] last;
    logic [W_DAC_CHAN-1:0] pick;
    logic [W_DAC_CHAN-1:0] cand;
    logic                  pick_ok;
    dac_state_t            dac_state;

    always_comb begin
        dac_hit = '0;
        for (int i = 0; i < N_DAC; i++) begin
            if (r_dv && int'(r_chan) == i) dac_hit[i] = 1'b1;
        end
    end

    // scan downward so the nearest channel after last wins
    always_comb begin
        pick    = last;
        cand    = last;
        pick_ok = 1'b0;
        for (int k = N_DAC; k >= 1; k--) begin
            cand = W_DAC_CHAN'((int'(last) + k) % N_DAC);
            if (dac_pend[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        dac_clr = '0;
        if (dac_state == DAC_IDLE && pick_ok) dac_clr[pick] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dac_state        <= DAC_IDLE;
            dac_pend         <= '0;
            last             <= W_DAC_CHAN'(N_DAC - 1);
            dac.dac_dv_out   <= 1'b0;
            dac.dac_chan_out <= '0;
            dac.dac_data_out <= '0;
            for (int i = 0; i < N_DAC; i++) dac_val[i] <= '0;
        end else begin
            dac_pend <= (dac_pend & ~dac_clr) | dac_hit;
            for (int i = 0; i < N_DAC; i++) begin
                if (dac_hit[i]) dac_val[i] <= r_data[W_DAC_DATA-1:0];
            end
            unique case (dac_state)
                DAC_IDLE: begin
                    if (pick_ok) begin
                        dac.dac_dv_out   <= 1'b1;
                        dac.dac_chan_out <= pick;
                        dac.dac_data_out <= dac_val[pick];
                        last             <= pick;
                        dac_state        <= DAC_SEND;
                    end
                end
                DAC_SEND: begin
                    if (dac.dac_rdy_in) begin
                        dac.dac_dv_out <= 1'b0;
                        dac_state      <= DAC_IDLE;
                    end
                end
                default: dac_state <= DAC_IDLE;
            endcase
        end
    end

    logic [N_DDS-1:0] dds_co;

    for (genvar g = 0; g < N_DDS; g++) begin : g_dds
        logic              hf;
        logic              hp;
        logic              ha;
        logic [1:0]        wsel;
        logic              sdv;
        logic [1:0]        ssel;
        logic [W_FREQ-1:0] sdata;

        assign hf = r_dv && (int'(r_chan) == FREQ0_ADDR + g);
        assign hp = r_dv && (int'(r_chan) == PHASE0_ADDR + g);
        assign ha = r_dv && (int'(r_chan) == AMP0_ADDR + g);

        always_comb begin
            wsel = SEL_FREQ;
            unique case (1'b1)
                hp:      wsel = SEL_PHASE;
                ha:      wsel = SEL_AMP;
                default: wsel = SEL_FREQ;
            endcase
        end

        dds_update_sequencer #(
            .W_FREQ (W_FREQ),
            .W_PHASE(W_PHASE),
            .W_AMP  (W_AMP)
        ) u_seq (
            .clk     (clk_in),
            .rst_n   (rst_n_in),
            .wr      (hf | hp | ha),
            .wr_sel  (wsel),
            .wr_data (r_data[W_FREQ-1:0]),
            .done    (dds_done_in[g]),
            .dv      (sdv),
            .sel     (ssel),
            .data    (sdata),
            .coalesce(dds_co[g])
        );

        assign dds_dv_out[g]                 = sdv;
        assign dds_sel_out[2*g +: 2]         = ssel;
        assign dds_data_out[W_FREQ*g +: W_FREQ] = sdata;
    end

`ifdef PID_OUTPUT_ROUTER_STATS_EN
    logic co_any;
    assign co_any = (|(dac_hit & dac_pend)) | (|dds_co);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            coalesce_cnt_out <= '0;
        end else if (co_any && coalesce_cnt_out != 16'hFFFF) begin
            coalesce_cnt_out <= coalesce_cnt_out + 16'd1;
        end
    end
`endif

endmodule
